// File: rtl/backend_cfg_pkg.sv
// Shared types and constants for the serial-configured analog backend.
// BACKEND_PARITY_EN adds a trailing odd-parity bit to every frame.
package backend_cfg_pkg;

  typedef enum logic [2:0] {INIT, READY, HDR, PAYLOAD, APPLY, SEQ, RUN} state_t;

  localparam logic [7:0] HDR_WORD = 8'hA5;

`ifdef BACKEND_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  function automatic int unsigned frame_len(input int unsigned num_ch, input int unsigned gain_w);
    return 8 + num_ch * gain_w + PARITY_BITS;
  endfunction

endpackage

// File: rtl/cfg_serial_rx.sv
// Oversampled serial receiver: sclk/sdin synchronisers, rising-edge detect,
// idle timeout and the bit shift register feeding the config FSM.
module cfg_serial_rx #(
  parameter int unsigned SHIFT_W = 7,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               sclk,
  input  logic               sdin,
  input  logic               enable,
  input  logic               arm,
  output logic               bit_valid,
  output logic               bit_data,
  output logic               timeout,
  output logic [SHIFT_W-1:0] shreg
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    sclk_sync;
  logic [1:0]    sdin_sync;
  logic          sclk_dly;
  logic [TW-1:0] idle_cnt;

  assign bit_valid = enable & sclk_sync[1] & ~sclk_dly;
  assign bit_data  = sdin_sync[1];
  // An edge in the expiry cycle suppresses the timeout and reloads the counter.
  assign timeout   = arm & ~bit_valid & (idle_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      sclk_sync <= '0;
      sdin_sync <= '0;
      sclk_dly  <= 1'b0;
      idle_cnt  <= '0;
      shreg     <= '0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      sdin_sync <= {sdin_sync[0], sdin};
      sclk_dly  <= sclk_sync[1];
      if (bit_valid)
        shreg <= {shreg[SHIFT_W-2:0], bit_data};
      if (!arm || bit_valid)
        idle_cnt <= '0;
      else if (idle_cnt != TO_LAST)
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/backend_cfg_multi.sv
// Multi-channel analog backend: serial config frames set gain codes and
// trigger a sequenced reset release. BACKEND_PARITY_EN enables frame parity.
module backend_cfg_multi
  import backend_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned GAIN_W   = 3,
  parameter int unsigned INIT_CYC = 32,
  parameter int unsigned RST_DLY  = 16,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic                     i_clk,
  input  logic                     i_resetbAll,
  input  logic                     i_sclk,
  input  logic                     i_sdin,
  output logic                     o_ready,
  output logic [NUM_CH*GAIN_W-1:0] o_gain,
  output logic [NUM_CH-1:0]        o_resetb,
  output logic                     o_resetbvco,
  output logic                     o_cfg_err
);

  localparam int unsigned PL      = NUM_CH * GAIN_W;
  localparam int unsigned FL      = frame_len(NUM_CH, GAIN_W);
  localparam int unsigned SW      = (PL + PARITY_BITS > 7) ? PL + PARITY_BITS : 7;
  localparam int unsigned SEQ_END = (NUM_CH + 1) * RST_DLY;
  localparam int unsigned CNT_MAX = (INIT_CYC > SEQ_END) ? INIT_CYC : SEQ_END;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned BW      = $clog2(FL + 1);

  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYC - 1);
  localparam logic [CW-1:0] VCO_AT    = CW'(SEQ_END);
  localparam logic [BW-1:0] HDR_LAST  = BW'(7);
  localparam logic [BW-1:0] FL_LAST   = BW'(FL - 1);

  state_t          state;
  state_t          origin;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_cnt;
  logic            enable;
  logic            arm;
  logic            bit_valid;
  logic            bit_data;
  logic            timeout;
  logic            frame_ok;
  logic [SW-1:0]   shreg;

  // The VCO reset is the last release, so it doubles as "chain released".
  assign origin = o_resetbvco ? RUN : READY;
  assign enable = state inside {READY, HDR, PAYLOAD, RUN};
  assign arm    = state inside {HDR, PAYLOAD};

  cfg_serial_rx #(
    .SHIFT_W (SW),
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clk       (i_clk),
    .resetb    (i_resetbAll),
    .sclk      (i_sclk),
    .sdin      (i_sdin),
    .enable    (enable),
    .arm       (arm),
    .bit_valid (bit_valid),
    .bit_data  (bit_data),
    .timeout   (timeout),
    .shreg     (shreg)
  );

`ifdef BACKEND_PARITY_EN
  logic par_acc;

  always_ff @(posedge i_clk) begin
    if (!i_resetbAll)
      par_acc <= 1'b0;
    else if (bit_valid)
      par_acc <= arm ? (par_acc ^ bit_data) : bit_data;
  end

  assign frame_ok = par_acc ^ bit_data;
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_resetbAll) begin
      state       <= INIT;
      cnt         <= '0;
      bit_cnt     <= '0;
      o_ready     <= 1'b0;
      o_gain      <= '0;
      o_resetb    <= '0;
      o_resetbvco <= 1'b0;
      o_cfg_err   <= 1'b0;
    end else begin
      o_cfg_err <= 1'b0;
      case (state)
        INIT: begin
          if (cnt == INIT_LAST) begin
            state   <= READY;
            o_ready <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY, RUN: begin
          if (bit_valid) begin
            state   <= HDR;
            bit_cnt <= BW'(1);
          end
        end
        HDR: begin
          if (timeout) begin
            o_cfg_err <= 1'b1;
            state     <= origin;
          end else if (bit_valid) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == HDR_LAST) begin
              if ({shreg[6:0], bit_data} == HDR_WORD) begin
                state <= PAYLOAD;
              end else begin
                o_cfg_err <= 1'b1;
                state     <= origin;
              end
            end
          end
        end
        PAYLOAD: begin
          if (timeout) begin
            o_cfg_err <= 1'b1;
            state     <= origin;
          end else if (bit_valid) begin
            if (bit_cnt == FL_LAST) begin
              if (frame_ok) begin
                state   <= APPLY;
                // Live reconfiguration keeps o_ready high; only the first apply drops it.
                o_ready <= o_resetbvco;
              end else begin
                o_cfg_err <= 1'b1;
                state     <= origin;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        APPLY: begin
          o_gain <= shreg[PARITY_BITS +: PL];
          if (o_resetbvco) begin
            state <= RUN;
          end else begin
            state <= SEQ;
            cnt   <= CW'(1);
          end
        end
        SEQ: begin
          cnt <= cnt + 1'b1;
          for (int unsigned k = 0; k < NUM_CH; k++)
            if (cnt == CW'((k + 1) * RST_DLY))
              o_resetb[k] <= 1'b1;
          if (cnt == VCO_AT) begin
            o_resetbvco <= 1'b1;
            o_ready     <= 1'b1;
            state       <= RUN;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
